// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for a single BRAM port, with grant lock,
// tagged read return and saturating per-requester stall counters.
module bram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                rq0_valid,
    output logic                rq0_ready,
    input  logic                rq0_we,
    input  logic [ADDR_W-1:0]   rq0_addr,
    input  logic [DATA_W-1:0]   rq0_wdata,
    input  logic                rq0_lock,
    output logic                rq0_rvalid,
    output logic [DATA_W-1:0]   rq0_rdata,

    input  logic                rq1_valid,
    output logic                rq1_ready,
    input  logic                rq1_we,
    input  logic [ADDR_W-1:0]   rq1_addr,
    input  logic [DATA_W-1:0]   rq1_wdata,
    input  logic                rq1_lock,
    output logic                rq1_rvalid,
    output logic [DATA_W-1:0]   rq1_rdata,

    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout,

    input  logic                stall_clr,
    output logic [15:0]         stall_cnt0,
    output logic [15:0]         stall_cnt1
);

    localparam int BE_W = DATA_W / 8;

    logic              last_grant;
    logic              lock_vld;
    logic              lock_id;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              gnt_id;
    logic              gnt_we;
    logic              gnt_lock;
    logic [RD_LAT-1:0] rd_vld;
    logic [RD_LAT-1:0] rd_id;

    // A lock only wins while its owner is still presenting a beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_vld && !lock_id && rq0_valid) begin
            gnt0 = 1'b1;
        end else if (lock_vld && lock_id && rq1_valid) begin
            gnt1 = 1'b1;
        end else if (rq0_valid && rq1_valid) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
        end else begin
            gnt0 = rq0_valid;
            gnt1 = rq1_valid;
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign gnt_id    = gnt1;
    assign gnt_we    = gnt1 ? rq1_we   : rq0_we;
    assign gnt_lock  = gnt1 ? rq1_lock : rq0_lock;
    assign rq0_ready = gnt0;
    assign rq1_ready = gnt1;

    assign bram_en   = gnt_any;
    assign bram_we   = {BE_W{gnt_any & gnt_we}};
    assign bram_addr = gnt1 ? rq1_addr  : (gnt0 ? rq0_addr  : '0);
    assign bram_din  = gnt1 ? rq1_wdata : (gnt0 ? rq0_wdata : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= 1'b1;
            lock_vld   <= 1'b0;
            lock_id    <= 1'b0;
        end else if (gnt_any) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            last_grant <= gnt_id;
            lock_vld   <= gnt_lock;
            lock_id    <= gnt_id;
        end else if (lock_vld) begin
            // Nothing granted while locked means the owner dropped valid.
            lock_vld   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the tag pipeline is reset so in-flight reads are dropped; the BRAM contents are not.
            rd_vld <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld[0] <= gnt_any & ~gnt_we;
            rd_id[0]  <= gnt_id;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_id[i]  <= rd_id[i-1];
            end
        end
    end

    assign rq0_rvalid = rd_vld[RD_LAT-1] & ~rd_id[RD_LAT-1];
    assign rq1_rvalid = rd_vld[RD_LAT-1] &  rd_id[RD_LAT-1];
    assign rq0_rdata  = rq0_rvalid ? bram_dout : '0;
    assign rq1_rdata  = rq1_rvalid ? bram_dout : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else if (stall_clr) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (rq0_valid && !gnt0 && stall_cnt0 != 16'hFFFF) stall_cnt0 <= stall_cnt0 + 16'd1;
            if (rq1_valid && !gnt1 && stall_cnt1 != 16'hFFFF) stall_cnt1 <= stall_cnt1 + 16'd1;
        end
    end

endmodule
